mem_unit_arb: RTL
=================

MEM_UNIT_ARB -- requirements
Module: mem_unit_arb

Interface
REQ-001 Parameter DATA_W, default 16, memory word width in bits.
REQ-002 Parameter ADDR_W, default 8, address width in bits.
REQ-003 Parameter DEPTH, default 256, number of implemented words; legal range 1..2**ADDR_W.
REQ-004 Parameter ARB_MODE, default 0, arbitration mode: 0 = data port fixed priority, 1 = round-robin.
REQ-005 CLK100MHZ  in  1  system clock; all state updates on the rising edge.
REQ-006 RST_N  in  1  asynchronous, active-low reset.
REQ-007 if_req  in  1  instruction-fetch read request; held until granted.
REQ-008 if_addr  in  ADDR_W  fetch address (PC).
REQ-009 if_gnt  out  1  fetch request accepted this cycle.
REQ-010 if_rvalid  out  1  if_rdata valid this cycle.
REQ-011 if_rdata  out  DATA_W  fetch read data.
REQ-012 dm_req  in  1  data-port request (control unit); held until granted.
REQ-013 dm_we  in  1  1 = write, 0 = read; qualified by dm_req.
REQ-014 dm_addr  in  ADDR_W  data-port address.
REQ-015 dm_wdata  in  DATA_W  write data (datapath A port).
REQ-016 dm_gnt  out  1  data request accepted this cycle.
REQ-017 dm_rvalid  out  1  dm_rdata valid this cycle.
REQ-018 dm_rdata  out  DATA_W  data-port read data.
REQ-019 err  out  1  sticky out-of-range access flag.
REQ-020 err_addr  out  ADDR_W  address of the first out-of-range access since reset.

Function
REQ-021 The array SHALL be single-ported: at most one access (read or write) per cycle.
REQ-022 if_gnt and dm_gnt SHALL be combinational from the current requests and arbiter state, and SHALL never both be 1.
REQ-023 A request alone SHALL be granted in the same cycle it is asserted.
REQ-024 With ARB_MODE=0 and both requests asserted, dm_gnt SHALL be 1 and if_gnt 0.
REQ-025 With ARB_MODE=1 and both requests asserted, the port not granted most recently SHALL be granted; the last-grant pointer SHALL update only on a grant.
REQ-026 A granted write SHALL update the array at the rising edge ending the grant cycle; a write produces no rvalid.
REQ-027 A granted read SHALL assert that port's rvalid for exactly one cycle, on the cycle after the grant, with the registered rdata.
REQ-028 A read of an address written in the preceding cycle SHALL return the new data.
REQ-029 rdata SHALL hold its last value while rvalid is 0.
REQ-030 An access with address >= DEPTH SHALL still be granted:
  - write: ignored, array unchanged;
  - read: rvalid asserted as normal, rdata = 0;
  - err set to 1, and err_addr captured only if err was 0.
REQ-031 err SHALL remain 1 until reset.
REQ-032 Back-to-back grants to the same port SHALL be sustained at one access per cycle.

Reset
REQ-033 While RST_N=0: if_rvalid, dm_rvalid, err = 0; if_rdata, dm_rdata, err_addr = 0; last-grant pointer = fetch, so data wins the first round-robin conflict.
REQ-034 Reset asserted in the cycle after a granted read SHALL clear rvalid immediately; no stale rvalid SHALL appear after reset release.
REQ-035 Array contents SHALL NOT be reset.
REQ-036 No grant SHALL be issued while RST_N=0.

Verification
REQ-037 Data write 0xBEEF @0x10, then fetch read @0x10 -> if_gnt the same cycle; if_rvalid=1 and if_rdata=0xBEEF one cycle later; dm_rvalid stays 0.
REQ-038 ARB_MODE=0, both ports requesting for 4 cycles -> dm_gnt=1 every cycle, if_gnt=0; the fetch is granted in the first cycle after dm_req drops.
REQ-039 ARB_MODE=1, both ports requesting for 4 cycles from reset -> grants alternate dm, if, dm, if.
REQ-040 DEPTH=200: write @0xC8, then read @0xC8 -> array unchanged, dm_rdata=0 with dm_rvalid, err=1, err_addr=0xC8. A later bad access @0xFF leaves err_addr=0xC8.
REQ-041 Write 0x1234 @0x05, then read @0x05 on the immediately following cycle -> dm_rdata=0x1234.
REQ-042 Assert RST_N=0 in the cycle after a granted read -> rvalid=0 at once and stays 0 after release; array word retains its value.

Source files
------------

// File: rtl/mem_unit_arb_if.sv
// mem_unit_arb_if -- request/response bundle between the two requesters
// (instruction fetch and data/control port) and the shared memory arbiter.
//
//   if_req / if_addr             fetch read request and address
//   if_gnt / if_rvalid / if_rdata fetch grant, read-valid and read data
//   dm_req / dm_we / dm_addr / dm_wdata   data-port request
//   dm_gnt / dm_rvalid / dm_rdata         data-port grant and read response
//   err / err_addr               sticky out-of-range flag and first bad address
//
// slave  : seen by the arbiter
// master : seen by the requesters (or a testbench)
interface mem_unit_arb_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 8
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_rvalid;
   logic [DATA_W-1:0] if_rdata;

   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic              dm_gnt;
   logic              dm_rvalid;
   logic [DATA_W-1:0] dm_rdata;

   logic              err;
   logic [ADDR_W-1:0] err_addr;

   modport slave (
      input  if_req, if_addr,
      input  dm_req, dm_we, dm_addr, dm_wdata,
      output if_gnt, if_rvalid, if_rdata,
      output dm_gnt, dm_rvalid, dm_rdata,
      output err, err_addr
   );

   modport master (
      output if_req, if_addr,
      output dm_req, dm_we, dm_addr, dm_wdata,
      input  if_gnt, if_rvalid, if_rdata,
      input  dm_gnt, dm_rvalid, dm_rdata,
      input  err, err_addr
   );
endinterface

// File: rtl/mem_unit_arb.sv
// mem_unit_arb -- single-ported memory shared by an instruction-fetch read
// port and a data read/write port.  One access per cycle; grants are
// combinational, reads return one cycle after the grant.
//
// Parameters
//   DATA_W   word width
//   ADDR_W   address width
//   DEPTH    implemented words (1 .. 2**ADDR_W); higher addresses are errors
//   ARB_MODE 0 = data port always wins a conflict, 1 = round-robin
// Ports
//   CLK100MHZ  system clock (rising edge)
//   RST_N      asynchronous active-low reset
//   bus        mem_unit_arb_if.slave: requests in, grants/read data/err out
module mem_unit_arb #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 8,
   parameter int DEPTH    = 256,
   parameter int ARB_MODE = 0
) (
   input  logic          CLK100MHZ,
   input  logic          RST_N,
   mem_unit_arb_if.slave bus
);

   localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

   // storage: no reset, registered read
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rd_raw_reg;

   // arbiter and response state
   logic              last_dm_reg;     // 1 = data port had the most recent grant
   logic              if_rvalid_reg;
   logic              dm_rvalid_reg;
   logic              rd_zero_reg;     // pending read was out of range
   logic [DATA_W-1:0] if_hold_reg;
   logic [DATA_W-1:0] dm_hold_reg;
   logic              err_reg;
   logic [ADDR_W-1:0] err_addr_reg;

   logic              if_gnt;
   logic              dm_gnt;
   logic              acc_en;
   logic              acc_we;
   logic              acc_in_range;
   logic [ADDR_W-1:0] acc_addr;
   logic [IDX_W-1:0]  acc_idx;
   logic              wr_en;
   logic              rd_en;
   logic [DATA_W-1:0] rd_word;

   // Grants are gated by RST_N so nothing is granted while reset is held.
   always_comb begin
      if_gnt = 1'b0;
      dm_gnt = 1'b0;
      if (RST_N) begin
         if (bus.dm_req && bus.if_req) begin
            if (ARB_MODE == 0) begin
               dm_gnt = 1'b1;
            end else begin
               // round-robin: whoever did not win last time wins now
               dm_gnt = !last_dm_reg;
               if_gnt = last_dm_reg;
            end
         end else begin
            dm_gnt = bus.dm_req;
            if_gnt = bus.if_req;
         end
      end
   end

   assign acc_en       = if_gnt | dm_gnt;
   assign acc_we       = dm_gnt & bus.dm_we;
   assign acc_addr     = dm_gnt ? bus.dm_addr : bus.if_addr;
   assign acc_in_range = ({1'b0, acc_addr} < DEPTH_L);
   assign acc_idx      = acc_addr[IDX_W-1:0];
   // out-of-range accesses never touch the array
   assign wr_en        = acc_we & acc_in_range;
   assign rd_en        = acc_en & !acc_we & acc_in_range;

   always_ff @(posedge CLK100MHZ) begin
      if (wr_en) begin
         mem[acc_idx] <= bus.dm_wdata;
      end
      if (rd_en) begin
         rd_raw_reg <= mem[acc_idx];
      end
   end

   assign rd_word = rd_zero_reg ? '0 : rd_raw_reg;

   always_ff @(posedge CLK100MHZ or negedge RST_N) begin
      if (!RST_N) begin
         last_dm_reg   <= 1'b0;
         if_rvalid_reg <= 1'b0;
         dm_rvalid_reg <= 1'b0;
         rd_zero_reg   <= 1'b0;
         if_hold_reg   <= '0;
         dm_hold_reg   <= '0;
         err_reg       <= 1'b0;
         err_addr_reg  <= '0;
      end else begin
         if (acc_en) begin
            last_dm_reg <= dm_gnt;
         end
         // the fetch port only ever reads
         if_rvalid_reg <= if_gnt;
         dm_rvalid_reg <= dm_gnt & !bus.dm_we;
         if (acc_en && !acc_we) begin
            rd_zero_reg <= !acc_in_range;
         end
         // remember the word being presented so rdata holds once rvalid drops
         if (if_rvalid_reg) begin
            if_hold_reg <= rd_word;
         end
         if (dm_rvalid_reg) begin
            dm_hold_reg <= rd_word;
         end
         if (acc_en && !acc_in_range) begin
            err_reg <= 1'b1;
            if (!err_reg) begin
               err_addr_reg <= acc_addr;
            end
         end
      end
   end

   assign bus.if_gnt    = if_gnt;
   assign bus.dm_gnt    = dm_gnt;
   assign bus.if_rvalid = if_rvalid_reg;
   assign bus.dm_rvalid = dm_rvalid_reg;
   assign bus.if_rdata  = if_rvalid_reg ? rd_word : if_hold_reg;
   assign bus.dm_rdata  = dm_rvalid_reg ? rd_word : dm_hold_reg;
   assign bus.err       = err_reg;
   assign bus.err_addr  = err_addr_reg;

endmodule
